// File: rtl/ureg_fanout_pkg.sv
// Shared types and constants for the ureg fan-out slice: slot index,
// in-order tracking entry and the fixed ureg bus widths.
package ureg_fanout_pkg;

    localparam int UREG_ADDR_W   = 12;
    localparam int UREG_STRB_W   = 8;
    localparam int UREG_DATA_W   = 64;
    localparam int MAX_SLOT_BITS = 4;

    localparam logic [UREG_DATA_W-1:0] ERR_DATA_DEFAULT = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef logic [MAX_SLOT_BITS-1:0] slot_idx_t;

    // is_local marks requests answered by the fan-out itself (slot out of range)
    typedef struct packed {
        logic      is_local;
        slot_idx_t slot;
    } track_entry_t;

endpackage

// File: rtl/ureg_fanout_ordq.sv
// In-order tracking FIFO for ureg_fanout: one entry per accepted request,
// extra-MSB pointers give full/empty without a separate counter register.
module ureg_fanout_ordq
    import ureg_fanout_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  track_entry_t           push_entry,
    input  logic                   pop,
    output track_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    track_entry_t mem [DEPTH];
    logic         push_ok;
    logic         pop_ok;

    assign push_ok = push & !full;
    assign pop_ok  = pop & !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end

    // Head is read combinationally so a response can be steered in the
    // same cycle it arrives from the application.
    assign head  = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/ureg_fanout.sv
// Fans one upstream ureg port out to NUM_APPS slots, returning responses in
// request order. Optional head timeout: define UREG_FANOUT_TIMEOUT_EN.
module ureg_fanout
    import ureg_fanout_pkg::*;
#(
    parameter int                     NUM_APPS        = 4,
    parameter int                     ADDR_WIDTH      = UREG_ADDR_W,
    parameter int                     SLOT_BITS       = 2,
    parameter int                     MAX_OUTSTANDING = 4,
    parameter logic [UREG_DATA_W-1:0] ERR_DATA        = ERR_DATA_DEFAULT,
    parameter int                     TIMEOUT_CYCLES  = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            ureg_req_rdy,
    input  logic                            ureg_req_val,
    input  logic [ADDR_WIDTH-1:0]           ureg_req_addr,
    input  logic [UREG_STRB_W-1:0]          ureg_req_strb,
    input  logic [UREG_DATA_W-1:0]          ureg_req_data,
    input  logic                            ureg_resp_rdy,
    output logic                            ureg_resp_val,
    output logic [UREG_DATA_W-1:0]          ureg_resp_data,
    output logic                            ureg_resp_ecc,
    output logic [NUM_APPS-1:0]             app_req_val,
    input  logic [NUM_APPS-1:0]             app_req_rdy,
    output logic [ADDR_WIDTH-SLOT_BITS-1:0] app_req_addr,
    output logic [UREG_STRB_W-1:0]          app_req_strb,
    output logic [UREG_DATA_W-1:0]          app_req_data,
    input  logic [NUM_APPS-1:0]             app_resp_val,
    output logic [NUM_APPS-1:0]             app_resp_rdy,
    input  logic [NUM_APPS*UREG_DATA_W-1:0] app_resp_data,
    input  logic [NUM_APPS-1:0]             app_resp_ecc
);

    logic [SLOT_BITS-1:0]         req_slot;
    logic                         req_local;
    logic [NUM_APPS-1:0]          req_hit;
    logic [NUM_APPS-1:0]          head_hit;
    logic [NUM_APPS-1:0]          fwd_ok;
    logic [NUM_APPS-1:0]          stale_drain;
    logic                         head_timed_out;
    logic [SLOT_BITS-1:0]         head_slot;
    logic                         run_reg;
    logic                         fifo_push;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    track_entry_t                 push_entry;
    track_entry_t                 head;
    logic                         unused_bits;

    // Holds the request side off until the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) run_reg <= 1'b0;
        else     run_reg <= 1'b1;
    end

    assign req_slot  = ureg_req_addr[ADDR_WIDTH-1 -: SLOT_BITS];
    assign req_local = (int'(req_slot) >= NUM_APPS);
    assign head_slot = head.slot[SLOT_BITS-1:0];

    for (genvar gi = 0; gi < NUM_APPS; gi++) begin : g_slot
        assign req_hit[gi]     = (req_slot == SLOT_BITS'(gi));
        assign app_req_val[gi] = run_reg & ureg_req_val & !fifo_full & req_hit[gi];
        assign head_hit[gi]    = !fifo_empty & !head.is_local & (head_slot == SLOT_BITS'(gi));
    end

    assign ureg_req_rdy = run_reg & !fifo_full & (req_local | (|(req_hit & app_req_rdy)));
    assign app_req_addr = ureg_req_addr[ADDR_WIDTH-SLOT_BITS-1:0];
    assign app_req_strb = ureg_req_strb;
    assign app_req_data = ureg_req_data;

    assign fifo_push           = ureg_req_val & ureg_req_rdy;
    assign push_entry.is_local = req_local;
    assign push_entry.slot     = slot_idx_t'(req_slot);
    assign fifo_pop            = ureg_resp_val & ureg_resp_rdy;

    ureg_fanout_ordq #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_ordq (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        ureg_resp_val  = 1'b0;
        ureg_resp_data = '0;
        ureg_resp_ecc  = 1'b0;
        app_resp_rdy   = stale_drain;
        if (!fifo_empty) begin
            if (head.is_local || head_timed_out) begin
                ureg_resp_val  = 1'b1;
                ureg_resp_data = ERR_DATA;
            end else begin
                for (int i = 0; i < NUM_APPS; i++) begin
                    if (head_hit[i]) begin
                        ureg_resp_val   = app_resp_val[i] & fwd_ok[i];
                        ureg_resp_data  = app_resp_data[UREG_DATA_W*i +: UREG_DATA_W];
                        ureg_resp_ecc   = app_resp_ecc[i];
                        app_resp_rdy[i] = ureg_resp_rdy & fwd_ok[i];
                    end
                end
            end
        end
    end

`ifdef UREG_FANOUT_TIMEOUT_EN
    localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STALE_W = $clog2(MAX_OUTSTANDING) + 2;

    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [STALE_W-1:0] stale_cnt_reg [NUM_APPS];
    logic [NUM_APPS-1:0] stale_inc;
    logic [NUM_APPS-1:0] stale_dec;
    logic               head_waiting;

    assign head_timed_out = !fifo_empty & !head.is_local &
                            (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES));
    assign head_waiting   = |(head_hit & ~(app_resp_val & fwd_ok));

    always_ff @(posedge clk) begin
        if (rst)                                 wait_cnt_reg <= '0;
        else if (fifo_pop)                       wait_cnt_reg <= '0;
        else if (head_waiting && !head_timed_out) wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end

    // A slot owing late responses has them swallowed before anything of
    // its own is forwarded again, keeping its response stream aligned.
    for (genvar gi = 0; gi < NUM_APPS; gi++) begin : g_stale
        assign fwd_ok[gi]      = (stale_cnt_reg[gi] == '0);
        assign stale_drain[gi] = !fwd_ok[gi];
        assign stale_inc[gi]   = fifo_pop & head_timed_out & head_hit[gi];
        assign stale_dec[gi]   = stale_drain[gi] & app_resp_val[gi];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_APPS; i++) begin
            if (rst)
                stale_cnt_reg[i] <= '0;
            else if (stale_inc[i] && !stale_dec[i] && stale_cnt_reg[i] != '1)
                stale_cnt_reg[i] <= stale_cnt_reg[i] + 1'b1;
            else if (stale_dec[i] && !stale_inc[i])
                stale_cnt_reg[i] <= stale_cnt_reg[i] - 1'b1;
        end
    end
`else
    assign head_timed_out = 1'b0;
    assign fwd_ok         = '1;
    assign stale_drain    = '0;
`endif

    assign unused_bits = ^{fifo_count, head.slot, (TIMEOUT_CYCLES != 0)};

endmodule

// File: tb/tb_ureg_fanout.sv
// Directed bench for ureg_fanout with three slots (slot 3 decodes locally);
// the timeout section runs when UREG_FANOUT_TIMEOUT_EN is defined.
module tb_ureg_fanout;

    localparam int          NA  = 3;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          ureg_req_rdy;
    logic          ureg_req_val;
    logic [11:0]   ureg_req_addr;
    logic [7:0]    ureg_req_strb;
    logic [63:0]   ureg_req_data;
    logic          ureg_resp_rdy;
    logic          ureg_resp_val;
    logic [63:0]   ureg_resp_data;
    logic          ureg_resp_ecc;
    logic [NA-1:0] app_req_val;
    logic [NA-1:0] app_req_rdy;
    logic [9:0]    app_req_addr;
    logic [7:0]    app_req_strb;
    logic [63:0]   app_req_data;
    logic [NA-1:0] app_resp_val;
    logic [NA-1:0] app_resp_rdy;
    logic [NA*64-1:0] app_resp_data;
    logic [NA-1:0] app_resp_ecc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ureg_fanout #(
        .NUM_APPS        (NA),
        .ADDR_WIDTH      (12),
        .SLOT_BITS       (2),
        .MAX_OUTSTANDING (4),
        .ERR_DATA        (ERR),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ureg_req_rdy   (ureg_req_rdy),
        .ureg_req_val   (ureg_req_val),
        .ureg_req_addr  (ureg_req_addr),
        .ureg_req_strb  (ureg_req_strb),
        .ureg_req_data  (ureg_req_data),
        .ureg_resp_rdy  (ureg_resp_rdy),
        .ureg_resp_val  (ureg_resp_val),
        .ureg_resp_data (ureg_resp_data),
        .ureg_resp_ecc  (ureg_resp_ecc),
        .app_req_val    (app_req_val),
        .app_req_rdy    (app_req_rdy),
        .app_req_addr   (app_req_addr),
        .app_req_strb   (app_req_strb),
        .app_req_data   (app_req_data),
        .app_resp_val   (app_resp_val),
        .app_resp_rdy   (app_resp_rdy),
        .app_resp_data  (app_resp_data),
        .app_resp_ecc   (app_resp_ecc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst && ureg_resp_val && ureg_resp_rdy)
            $display("[%0t] resp data=%h ecc=%b", $time, ureg_resp_data, ureg_resp_ecc);
    end

    initial begin
        rst           = 1'b1;
        ureg_req_val  = 1'b1;
        ureg_req_addr = 12'h000;
        ureg_req_strb = 8'h00;
        ureg_req_data = 64'h0;
        ureg_resp_rdy = 1'b1;
        app_req_rdy   = 3'b111;
        app_resp_val  = 3'b000;
        app_resp_data = '0;
        app_resp_ecc  = 3'b000;

        // reset state, with a request pending to prove it is not accepted
        repeat (3) step();
        #1;
        check("rst_req_rdy", 64'(ureg_req_rdy), 64'd0);
        check("rst_resp_val", 64'(ureg_resp_val), 64'd0);
        check("rst_resp_data", ureg_resp_data, 64'd0);
        check("rst_resp_ecc", 64'(ureg_resp_ecc), 64'd0);
        check("rst_app_req_val", 64'(app_req_val), 64'd0);
        check("rst_app_resp_rdy", 64'(app_resp_rdy), 64'd0);
        ureg_req_val = 1'b0;
        rst = 1'b0;
        step();
        #1;
        check("post_rst_req_rdy", 64'(ureg_req_rdy), 64'd1);

        // read slot 2, response 3 cycles later
        ureg_req_val = 1'b1; ureg_req_addr = 12'h810;
        #1;
        check("t1_app_req_val", 64'(app_req_val), 64'b100);
        check("t1_app_req_addr", 64'(app_req_addr), 64'h010);
        check("t1_same_cycle_resp", 64'(ureg_resp_val), 64'd0);
        step();
        ureg_req_val = 1'b0;
        #1;
        check("t1_wait_resp_val", 64'(ureg_resp_val), 64'd0);
        check("t1_app_resp_rdy", 64'(app_resp_rdy), 64'b100);
        step(); step();
        app_resp_val = 3'b100; app_resp_data[128 +: 64] = 64'h1234; app_resp_ecc = 3'b100;
        #1;
        check("t1_resp_val", 64'(ureg_resp_val), 64'd1);
        check("t1_resp_data", ureg_resp_data, 64'h1234);
        check("t1_resp_ecc", 64'(ureg_resp_ecc), 64'd1);
        step();
        app_resp_val = 3'b000; app_resp_ecc = 3'b000;
        #1;
        check("t1_once_resp_val", 64'(ureg_resp_val), 64'd0);
        check("t1_idle_app_resp_rdy", 64'(app_resp_rdy), 64'd0);

        // write slot 0 then read slot 1; slot 1 answers first and must wait
        ureg_req_val = 1'b1; ureg_req_addr = 12'h004; ureg_req_strb = 8'hFF; ureg_req_data = 64'h55;
        #1;
        check("t2_wr_app_req_val", 64'(app_req_val), 64'b001);
        check("t2_wr_app_req_strb", 64'(app_req_strb), 64'hFF);
        check("t2_wr_app_req_data", app_req_data, 64'h55);
        step();
        ureg_req_addr = 12'h400; ureg_req_strb = 8'h00;
        #1;
        check("t2_rd_app_req_val", 64'(app_req_val), 64'b010);
        step();
        ureg_req_val = 1'b0;
        app_resp_val = 3'b010; app_resp_data[64 +: 64] = 64'h1111;
        #1;
        check("t2_hold_resp_val", 64'(ureg_resp_val), 64'd0);
        check("t2_hold_app_resp_rdy", 64'(app_resp_rdy), 64'b001);
        step();
        #1;
        check("t2_still_held", 64'(ureg_resp_val), 64'd0);
        app_resp_val = 3'b011; app_resp_data[0 +: 64] = 64'hAAAA;
        #1;
        check("t2_first_val", 64'(ureg_resp_val), 64'd1);
        check("t2_first_data", ureg_resp_data, 64'hAAAA);
        step();
        app_resp_val = 3'b010;
        #1;
        check("t2_second_val", 64'(ureg_resp_val), 64'd1);
        check("t2_second_data", ureg_resp_data, 64'h1111);
        check("t2_second_app_resp_rdy", 64'(app_resp_rdy), 64'b010);
        step();
        app_resp_val = 3'b000;
        #1;
        check("t2_done", 64'(ureg_resp_val), 64'd0);

        // out-of-range slot 3 answered locally
        app_req_rdy = 3'b000; app_resp_ecc = 3'b111;
        ureg_req_val = 1'b1; ureg_req_addr = 12'hC00;
        #1;
        check("t3_app_req_val", 64'(app_req_val), 64'd0);
        check("t3_req_rdy", 64'(ureg_req_rdy), 64'd1);
        check("t3_same_cycle_resp", 64'(ureg_resp_val), 64'd0);
        step();
        ureg_req_val = 1'b0;
        #1;
        check("t3_resp_val", 64'(ureg_resp_val), 64'd1);
        check("t3_resp_data", ureg_resp_data, ERR);
        check("t3_resp_ecc", 64'(ureg_resp_ecc), 64'd0);
        step();
        #1;
        check("t3_popped", 64'(ureg_resp_val), 64'd0);
        app_req_rdy = 3'b111; app_resp_ecc = 3'b000;

        // fill the tracking FIFO, then hold backpressure
        ureg_resp_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ureg_req_val = 1'b1; ureg_req_addr = 12'(i);
            #1;
            check($sformatf("t4_fill_rdy_%0d", i), 64'(ureg_req_rdy), 64'd1);
            step();
        end
        ureg_req_addr = 12'h010;
        app_resp_val = 3'b001; app_resp_data[0 +: 64] = 64'hBEEF;
        #1;
        check("t4_full_req_rdy", 64'(ureg_req_rdy), 64'd0);
        check("t4_full_app_req_val", 64'(app_req_val), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t4_bp_val_%0d", i), 64'(ureg_resp_val), 64'd1);
            check($sformatf("t4_bp_data_%0d", i), ureg_resp_data, 64'hBEEF);
            check($sformatf("t4_bp_app_rdy_%0d", i), 64'(app_resp_rdy), 64'd0);
            step();
        end
        ureg_resp_rdy = 1'b1;
        #1;
        check("t4_pop_cycle_req_rdy", 64'(ureg_req_rdy), 64'd0);
        step();
        ureg_resp_rdy = 1'b0;
        #1;
        check("t4_after_pop_req_rdy", 64'(ureg_req_rdy), 64'd1);
        step();
        ureg_req_val = 1'b0; ureg_resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_drain_%0d", i), 64'(ureg_resp_val), 64'd1);
            step();
        end
        #1;
        check("t4_drained", 64'(ureg_resp_val), 64'd0);
        app_resp_val = 3'b000;

        // reset with a read outstanding: it is forgotten
        ureg_req_val = 1'b1; ureg_req_addr = 12'h400;
        step();
        ureg_req_val = 1'b0;
        #1;
        check("t5_outstanding_app_rdy", 64'(app_resp_rdy), 64'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        app_resp_val = 3'b010; app_resp_data[64 +: 64] = 64'h9999;
        #1;
        check("t5_after_rst_app_rdy", 64'(app_resp_rdy), 64'd0);
        check("t5_after_rst_resp_val", 64'(ureg_resp_val), 64'd0);
        step();
        app_resp_val = 3'b000;

`ifdef UREG_FANOUT_TIMEOUT_EN
        // slot 1 stays silent past the timeout, then answers late
        ureg_req_val = 1'b1; ureg_req_addr = 12'h400;
        step();
        ureg_req_val = 1'b0;
        repeat (15) step();
        #1;
        check("t6_before_timeout", 64'(ureg_resp_val), 64'd0);
        step();
        #1;
        check("t6_timeout_val", 64'(ureg_resp_val), 64'd1);
        check("t6_timeout_data", ureg_resp_data, ERR);
        check("t6_timeout_ecc", 64'(ureg_resp_ecc), 64'd0);
        step();
        #1;
        check("t6_stale_app_rdy", 64'(app_resp_rdy), 64'b010);
        app_resp_val = 3'b010; app_resp_data[64 +: 64] = 64'h7777;
        #1;
        check("t6_late_not_fwd", 64'(ureg_resp_val), 64'd0);
        step();
        app_resp_val = 3'b000;
        #1;
        check("t6_stale_cleared", 64'(app_resp_rdy), 64'd0);
        ureg_req_val = 1'b1; ureg_req_addr = 12'h400;
        step();
        ureg_req_val = 1'b0;
        app_resp_val = 3'b010; app_resp_data[64 +: 64] = 64'h8888;
        #1;
        check("t6_next_val", 64'(ureg_resp_val), 64'd1);
        check("t6_next_data", ureg_resp_data, 64'h8888);
        step();
        app_resp_val = 3'b000;
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
